uart_cmd_bridge: RTL and testbench
==================================

# uart_cmd_bridge

Byte-level command bridge that lets a remote UART host drive the 4-entry register interface. Consumes received bytes from a UART receiver, decodes read/write command frames, issues single-cycle `we`/`re` strobes with `address`/`write_data` toward the register block, and returns an acknowledge byte or read data through a UART transmitter byte handshake. Sits between the rx/tx byte cores and the register interface, acting as its bus initiator.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle cycles allowed between bytes of a write frame before the frame is discarded; legal range ≥2.
- `ACK_BYTE`, default 8'hA5: byte returned after a completed write.
- `clk` in 1: single clock; all logic rises on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle pulse; `rx_byte` valid; no backpressure possible.
- `rx_byte` in 8: received byte.
- `tx_valid` out 1: response byte available.
- `tx_byte` out 8: response byte; stable while `tx_valid`=1.
- `tx_ready` in 1: transmitter accepts; transfer when `tx_valid`&`tx_ready`.
- `address` out 2: register address.
- `write_data` out 32: register write data.
- `we` out 1: one-cycle write strobe.
- `re` out 1: one-cycle read strobe.
- `read_data` in 8: register read data, valid the cycle after `re`.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; set when a byte is dropped.
- `timeout` out 1: one-cycle pulse when a write frame is abandoned.

## Operation
- Frame format: command byte `{rw, 5'bx, addr[1:0]}`; `rw`=1 write, 0 read; bits[6:2] ignored.
- Write frame: command + 4 data bytes, little-endian (first byte → `write_data[7:0]`). Response: `ACK_BYTE`.
- Read frame: command only. Response: the byte sampled from `read_data`.
- States: IDLE, WDATA, WRITE, READ, RCAP, RESP.
- IDLE: on `rx_valid`, latch `addr` into `address`; `rw`=1 → WDATA with byte count 0; `rw`=0 → READ.
- WDATA: on each `rx_valid`, shift byte into slot `count`, count+1, timeout counter cleared; on the 4th byte → WRITE. If timeout counter reaches `TIMEOUT_CYCLES`-1 with no `rx_valid` → IDLE, `timeout`=1 for that transition cycle, no `we`, partial data discarded.
- WRITE: `we`=1 for exactly this cycle, `address`/`write_data` stable; → RESP with `tx_byte`=`ACK_BYTE`.
- READ: `re`=1 for exactly this cycle; → RCAP.
- RCAP: `read_data` registered into `tx_byte` at the end of this cycle; → RESP.
- RESP: `tx_valid`=1; on `tx_ready`=1 → IDLE (`tx_valid` low next cycle).
- `rx_valid` in WRITE, READ, RCAP or RESP: byte dropped, `overrun` set; state unaffected.
- Byte count 2 bits, wraps only by leaving WDATA; timeout counter width ⌈log2(TIMEOUT_CYCLES+1)⌉, saturates never (exit first).
- `address`, `write_data` hold last values outside active frames.

## Timing
- Reset values: state IDLE; `tx_valid`, `we`, `re`, `busy`, `overrun`, `timeout` = 0; `tx_byte`, `address`, `write_data` = 0; counters 0.
- Reset mid-frame (any state): next cycle IDLE, partial frame dropped, no strobe, pending response discarded.
- Write latency: `we` asserted 1 cycle after the cycle carrying the 4th `rx_valid`; `tx_valid` 1 cycle after `we`.
- Read latency: `re` 1 cycle after the command `rx_valid`; `tx_valid` 2 cycles after `re`.
- Earliest next command accepted: cycle after the `tx_valid`&`tx_ready` handshake.
- `rx_valid` on the same cycle the timeout would fire: byte wins, counter clears, no `timeout`.
- `tx_ready` may be held high permanently; `tx_valid` then lasts exactly 1 cycle.

## Test plan
- Write: bytes 0x82,0x78,0x56,0x34,0x12 → one `we` pulse, `address`=2, `write_data`=0x12345678; then `tx_byte`=0xA5 with one handshake.
- Read: byte 0x03, `read_data`=0x5C the cycle after `re` → `re` one cycle with `address`=3, `tx_byte`=0x5C.
- Backpressure: read with `tx_ready` low 20 cycles → `tx_valid`/`tx_byte` stable 20 cycles, single transfer, `busy` low after.
- Timeout: 0x81,0x11 then silence (TIMEOUT_CYCLES=16) → `timeout` pulse, no `we`, IDLE; following 0x00 read completes normally.
- Overrun: extra byte during RESP → `overrun`=1 and stays 1, response byte unchanged, next frame works.
- Reset mid-frame: `rst` after 2 data bytes of a write → all outputs 0, no `we`, next write frame writes correct data.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
// Byte-level command bridge: turns UART command frames into single-cycle
// register strobes and returns an acknowledge or read-data byte.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command byte
// WDATA  | collecting the 4 little-endian data bytes of a write frame
// WRITE  | we strobe, address/write_data stable
// READ   | re strobe toward the register block
// RCAP   | read_data valid this cycle, captured into tx_byte
// RESP   | tx_valid high until the transmitter accepts
module uart_cmd_bridge #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic [1:0]  address,
    output logic [31:0] write_data,
    output logic        we,
    output logic        re,
    input  logic [7:0]  read_data,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TC_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WRITE,
        S_READ,
        S_RCAP,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     count;
    logic [TW-1:0]  tcnt;
    // first three data bytes; the fourth goes straight into write_data so a
    // partial frame never disturbs the value last presented to the registers
    logic [23:0]    data_buf;
    logic           tc_hit;
    logic           drop_byte;

    assign tc_hit    = (tcnt == TC_LAST);
    assign drop_byte = rx_valid && ((state == S_WRITE) || (state == S_READ) ||
                                    (state == S_RCAP)  || (state == S_RESP));

    // next-state decode and strobe/handshake outputs
    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        re        = 1'b0;
        tx_valid  = 1'b0;
        timeout   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    state_nxt = rx_byte[7] ? S_WDATA : S_READ;
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    if (count == 2'd3) begin
                        state_nxt = S_WRITE;
                    end
                end else if (tc_hit) begin
                    state_nxt = S_IDLE;
                    timeout   = 1'b1;
                end
            end
            S_WRITE: begin
                we        = 1'b1;
                state_nxt = S_RESP;
            end
            S_READ: begin
                re        = 1'b1;
                state_nxt = S_RCAP;
            end
            S_RCAP: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // frame datapath: address latch, byte assembly, inter-byte timer, response byte
    always_ff @(posedge clk) begin
        if (rst) begin
            address    <= '0;
            write_data <= '0;
            data_buf   <= '0;
            count      <= '0;
            tcnt       <= '0;
            tx_byte    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        address <= rx_byte[1:0];
                        count   <= '0;
                        tcnt    <= '0;
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        count <= count + 2'd1;
                        tcnt  <= '0;
                        if (count == 2'd3) begin
                            write_data <= {rx_byte, data_buf};
                        end else begin
                            data_buf <= {rx_byte, data_buf[23:8]};
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    tx_byte <= ACK_BYTE;
                end
                S_RCAP: begin
                    tx_byte <= read_data;
                end
                default: begin
                end
            endcase
        end
    end

    // sticky flag for bytes that arrive while a frame is being executed
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop_byte) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Testbench for uart_cmd_bridge: directed vector table, hand-written
// multi-cycle sequences and randomized frames checked against a frame-level
// reference model.
module tb_uart_cmd_bridge;

    localparam int         TO  = 16;
    localparam logic [7:0] ACK = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready = 1'b0;
    logic [1:0]  address;
    logic [31:0] write_data;
    logic        we;
    logic        re;
    logic [7:0]  read_data = '0;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    // monitor log
    int          we_cnt, re_cnt, hs_cnt, to_cnt;
    logic [1:0]  we_addr, re_addr;
    logic [31:0] we_data;
    logic [7:0]  hs_byte;
    logic        re_prev = 1'b0;
    logic [7:0]  rd_val = '0;
    logic [31:0] last_wdata = '0;

    uart_cmd_bridge #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(ACK)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .address(address), .write_data(write_data),
        .we(we), .re(re), .read_data(read_data),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // observe strobes and handshakes mid-cycle
    always @(negedge clk) begin
        re_prev = re;
        if (we) begin
            we_cnt++;
            we_addr = address;
            we_data = write_data;
        end
        if (re) begin
            re_cnt++;
            re_addr = address;
        end
        if (tx_valid && tx_ready) begin
            hs_cnt++;
            hs_byte = tx_byte;
        end
        if (timeout) to_cnt++;
    end

    // register block model: read_data valid only in the cycle after re
    always @(posedge clk) begin
        #1;
        read_data = re_prev ? rd_val : 8'($urandom);
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [7:0]  rd;
        int          gap;
        int          hold;
        logic        exp_we;
        logic [1:0]  exp_addr;
        logic [7:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        we_cnt = 0; re_cnt = 0; hs_cnt = 0; to_cnt = 0;
        hs_byte = 'x;
    endtask

    // frame-level reference: what the register block and host should see
    function automatic void ref_model(input logic [7:0] cmd, input logic [7:0] rd,
                                      output logic w, output logic [1:0] a, output logic [7:0] resp);
        w    = cmd[7];
        a    = cmd[1:0];
        resp = cmd[7] ? ACK : rd;
    endfunction

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] data, input logic [7:0] rd,
                             input int gap, input int hold, input logic exp_we,
                             input logic [1:0] exp_addr, input logic [7:0] exp_resp, input string tag);
        int n;
        logic ok;
        clear_log();
        rd_val   = rd;
        tx_ready = 1'b0;
        send_byte(cmd);
        if (exp_we) begin
            for (int i = 0; i < 4; i++) begin
                repeat (gap) step();
                send_byte(data[8*i +: 8]);
            end
        end
        n = 0;
        while (!tx_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, "_txv"}, tx_valid, 1'b1);
        ok = 1'b1;
        repeat (hold) begin
            if (!tx_valid || tx_byte !== exp_resp) ok = 1'b0;
            step();
        end
        check({tag, "_hold"}, ok, 1'b1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check({tag, "_hs"}, hs_cnt, 1);
        check({tag, "_resp"}, hs_byte, exp_resp);
        check({tag, "_we_n"}, we_cnt, exp_we ? 1 : 0);
        check({tag, "_re_n"}, re_cnt, exp_we ? 0 : 1);
        check({tag, "_busy"}, busy, 1'b0);
        if (exp_we) begin
            last_wdata = data;
            check({tag, "_waddr"}, we_addr, exp_addr);
            check({tag, "_wdata"}, we_data, data);
        end else begin
            check({tag, "_raddr"}, re_addr, exp_addr);
            check({tag, "_wd_hold"}, write_data, last_wdata);
        end
    endtask

    initial begin
        int first;
        int vcnt;
        logic ok;
        logic [7:0]  c, rdr;
        logic [31:0] d;
        logic        ew;
        logic [1:0]  ea;
        logic [7:0]  er;

        vecs[0] = '{8'h82, 32'h12345678, 8'h00, 0, 0, 1'b1, 2'd2, ACK};
        vecs[1] = '{8'h03, 32'h0,        8'h5C, 0, 0, 1'b0, 2'd3, 8'h5C};
        vecs[2] = '{8'hFD, 32'hDEADBEEF, 8'h00, 2, 3, 1'b1, 2'd1, ACK};
        vecs[3] = '{8'h7C, 32'h0,        8'hFF, 0, 1, 1'b0, 2'd0, 8'hFF};
        vecs[4] = '{8'h80, 32'h00000000, 8'h00, 1, 0, 1'b1, 2'd0, ACK};
        vecs[5] = '{8'h42, 32'h0,        8'h00, 0, 2, 1'b0, 2'd2, 8'h00};

        clear_log();
        repeat (3) step();
        check("rst_outs", {tx_valid, we, re, busy, overrun, timeout, tx_byte, address}, '0);
        check("rst_wdata", write_data, 32'h0);
        rst = 1'b0;
        step();
        check("idle_outs", {tx_valid, we, re, busy, overrun, timeout}, '0);

        // write latency
        clear_log();
        send_byte(8'h82); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        check("wr_no_early_we", we, 1'b0);
        send_byte(8'h12);
        check("wr_we", we, 1'b1);
        check("wr_addr", address, 2'd2);
        check("wr_data", write_data, 32'h12345678);
        check("wr_txv_early", tx_valid, 1'b0);
        step();
        check("wr_we_off", we, 1'b0);
        check("wr_txv", tx_valid, 1'b1);
        check("wr_ack", tx_byte, ACK);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        check("wr_hs", hs_cnt, 1);
        check("wr_idle", {busy, tx_valid}, 2'b00);
        last_wdata = 32'h12345678;

        // read latency
        clear_log();
        rd_val = 8'h5C;
        send_byte(8'h03);
        check("rd_re", re, 1'b1);
        check("rd_addr", address, 2'd3);
        step();
        check("rd_rcap", {re, tx_valid}, 2'b00);
        step();
        check("rd_txv", tx_valid, 1'b1);
        check("rd_byte", tx_byte, 8'h5C);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        check("rd_hs", hs_cnt, 1);
        check("rd_re_n", re_cnt, 1);

        // backpressure for 20 cycles
        clear_log();
        rd_val = 8'h3A;
        send_byte(8'h01);
        step(); step();
        ok = 1'b1;
        repeat (20) begin
            if (!tx_valid || tx_byte !== 8'h3A) ok = 1'b0;
            step();
        end
        check("bp_stable", ok, 1'b1);
        check("bp_no_hs", hs_cnt, 0);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        check("bp_hs", hs_cnt, 1);
        check("bp_byte", hs_byte, 8'h3A);
        check("bp_busy", busy, 1'b0);

        // tx_ready held high: one-cycle tx_valid
        clear_log();
        rd_val = 8'h99;
        tx_ready = 1'b1;
        send_byte(8'h02);
        vcnt = 0;
        repeat (8) begin
            if (tx_valid) vcnt++;
            step();
        end
        tx_ready = 1'b0;
        check("rdy_hi_vcnt", vcnt, 1);
        check("rdy_hi_hs", hs_cnt, 1);
        check("rdy_hi_byte", hs_byte, 8'h99);

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].cmd, vecs[i].data, vecs[i].rd, vecs[i].gap, vecs[i].hold,
                      vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_resp, $sformatf("vec%0d", i));
        end

        // timeout after TO idle cycles in a write frame
        clear_log();
        send_byte(8'h81);
        send_byte(8'h11);
        first = 0;
        for (int i = 1; i <= 24; i++) begin
            if (timeout) begin
                first = i;
                break;
            end
            step();
        end
        check("to_cycle", first, TO);
        step();
        check("to_pulse_off", timeout, 1'b0);
        check("to_busy", busy, 1'b0);
        check("to_cnt", to_cnt, 1);
        check("to_no_we", we_cnt, 0);
        run_frame(8'h00, 32'h0, 8'h6E, 0, 0, 1'b0, 2'd0, 8'h6E, "to_rd");

        // byte arriving on the would-be timeout cycle wins
        clear_log();
        send_byte(8'h81);
        repeat (TO - 1) step();
        rx_valid = 1'b1;
        rx_byte  = 8'hA1;
        #1;
        check("race_no_to", timeout, 1'b0);
        step();
        rx_valid = 1'b0;
        send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        check("race_we", we, 1'b1);
        check("race_data", write_data, 32'hD4C3B2A1);
        check("race_addr", address, 2'd1);
        tx_ready = 1'b1; step(); step(); tx_ready = 1'b0;
        check("race_to_cnt", to_cnt, 0);
        check("race_hs", hs_cnt, 1);
        last_wdata = 32'hD4C3B2A1;

        // overrun during RESP
        clear_log();
        send_byte(8'h80);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        step();
        check("ovr_pre", overrun, 1'b0);
        send_byte(8'hEE);
        check("ovr_set", overrun, 1'b1);
        check("ovr_txv", tx_valid, 1'b1);
        check("ovr_byte", tx_byte, ACK);
        tx_ready = 1'b1; step(); tx_ready = 1'b0;
        check("ovr_hs", hs_cnt, 1);
        check("ovr_we_data", we_data, 32'hCAFEF00D);
        last_wdata = 32'hCAFEF00D;
        run_frame(8'h05, 32'h0, 8'h17, 0, 1, 1'b0, 2'd1, 8'h17, "ovr_next");
        check("ovr_sticky", overrun, 1'b1);

        // reset in the middle of a write frame
        clear_log();
        send_byte(8'h83); send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        step();
        check("mid_rst_outs", {tx_valid, we, re, busy, overrun, timeout, tx_byte, address}, '0);
        check("mid_rst_wdata", write_data, 32'h0);
        rst = 1'b0;
        repeat (3) step();
        check("mid_rst_no_we", we_cnt, 0);
        check("mid_rst_idle", busy, 1'b0);
        last_wdata = 32'h0;
        run_frame(8'h83, 32'h55667788, 8'h00, 0, 0, 1'b1, 2'd3, ACK, "mid_rst_wr");

        // randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            c   = 8'($urandom);
            d   = $urandom;
            rdr = 8'($urandom);
            ref_model(c, rdr, ew, ea, er);
            run_frame(c, d, rdr, $urandom_range(0, 4), $urandom_range(0, 3), ew, ea, er,
                      $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
